// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared state encoding and default sizes for the APB requester
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W      = 10;
  localparam int APB_DATA_W      = 32;
  localparam int APB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_master_wdog.sv
// rtl/apb_master_wdog.sv - ACCESS-phase cycle counter; expired is high during the LIMIT-th enabled cycle
module apb_master_wdog
  import apb_master_pkg::*;
#(
  parameter int LIMIT = APB_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready command to APB SETUP/ACCESS requester, one transfer outstanding
// Define APB_MASTER_TIMEOUT_EN to build the ACCESS watchdog (rsp_err otherwise tied low).
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
  input  logic                  pclk,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  apb_state_e state, state_next;
  logic       accept;
  logic       done;
  logic       expired;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be within 2..65535");
  end

  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready || expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = PRESETn && (state == IDLE);
    accept    = cmd_ready && cmd_valid;
    done      = (state == ACCESS) && (pready || expired);
  end

  // APB outputs live in flops; address/data are left as-is between transfers.
  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      if (accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
        psel   <= 1'b1;
      end
      if (state == SETUP) penable <= 1'b1;
      if (done) begin
        psel      <= 1'b0;
        penable   <= 1'b0;
        rsp_rdata <= (pwrite || !pready) ? '0 : prdata;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (pclk),
    .rst_n   (PRESETn),
    .clear   (accept),
    .en      (state == ACCESS),
    .expired (expired)
  );

  // A late pready on the expiry edge wins over the timeout.
  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) rsp_err <= 1'b0;
    else          rsp_err <= done && !pready;
  end
`else
  assign expired = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;

  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO_LIMIT = TO;
`else
  localparam int TO_LIMIT = 1 << 30;
`endif

  logic        pclk = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  paddr;
  logic        pwrite, psel, penable, pready;
  logic [31:0] pwdata, prdata;

  int total = 0;
  int bad   = 0;

  apb_master #(
    .ADDR_WIDTH     (10),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk      (pclk),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_write (cmd_write),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Protocol monitor, sampled on the falling edge.
  logic        m_valid = 1'b0;
  logic        m_psel, m_pen, m_pwrite, m_pready;
  logic [9:0]  m_paddr;
  logic [31:0] m_pwdata;
  int          m_acc = 0;
  int          m_prev_acc = 0;

  always @(negedge pclk) begin
    if (!PRESETn) begin
      m_valid = 1'b0;
      m_acc   = 0;
    end else begin
      m_prev_acc = m_acc;
      m_acc = (psel && penable) ? m_acc + 1 : 0;
      total = total + 1;
      if (penable && !psel) begin
        bad = bad + 1;
        $display("FAIL proto_penable_psel: penable=%b psel=%b, need psel when penable", penable, psel);
      end
      if (penable && !(m_valid && m_pen)) begin
        total = total + 1;
        if (!(m_valid && m_psel && !m_pen)) begin
          bad = bad + 1;
          $display("FAIL proto_setup_first: prev psel=%b penable=%b, need SETUP before ACCESS", m_psel, m_pen);
        end
      end
      if (m_valid && m_psel && m_pen && !m_pready && (m_prev_acc < TO_LIMIT)) begin
        total = total + 1;
        if ({psel, penable, pwrite, paddr, pwdata} !== {m_psel, m_pen, m_pwrite, m_paddr, m_pwdata}) begin
          bad = bad + 1;
          $display("FAIL proto_stable: got %b%b%b %h %h, need %b%b%b %h %h", psel, penable, pwrite,
                   paddr, pwdata, m_psel, m_pen, m_pwrite, m_paddr, m_pwdata);
        end
      end
      m_valid  = 1'b1;
      m_psel   = psel;
      m_pen    = penable;
      m_pwrite = pwrite;
      m_pready = pready;
      m_paddr  = paddr;
      m_pwdata = pwdata;
    end
  end

  task automatic test_reset();
    #3;
    total = total + 4;
    if ({psel, penable} !== 2'b00) begin
      bad = bad + 1; $display("FAIL reset_psel_penable: got %b, need 00", {psel, penable});
    end
    if ({paddr, pwrite, pwdata} !== 43'd0) begin
      bad = bad + 1; $display("FAIL reset_addr_data: got %h %b %h, need zeros", paddr, pwrite, pwdata);
    end
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) begin
      bad = bad + 1; $display("FAIL reset_rsp: got %b %b %h, need zeros", rsp_valid, rsp_err, rsp_rdata);
    end
    if (cmd_ready !== 1'b0) begin
      bad = bad + 1; $display("FAIL reset_cmd_ready: got %b, need 0", cmd_ready);
    end
    tick();
    PRESETn = 1'b1;
    #1;
    total = total + 1;
    if (cmd_ready !== 1'b1) begin
      bad = bad + 1; $display("FAIL reset_release_ready: got %b, need 1", cmd_ready);
    end
  endtask

  task automatic test_zero_wait_write();
    tick();
    cmd_addr = 10'h004; cmd_write = 1'b1; cmd_wdata = 32'hDEADBEEF;
    cmd_valid = 1'b1; pready = 1'b1;
    total = total + 1;
    if (cmd_ready !== 1'b1) begin
      bad = bad + 1; $display("FAIL zw_idle_ready: got %b, need 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    total = total + 2;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1000) begin
      bad = bad + 1; $display("FAIL zw_setup: psel/pen/ready/rsp got %b, need 1000", {psel, penable, cmd_ready, rsp_valid});
    end
    if ({paddr, pwrite, pwdata} !== {10'h004, 1'b1, 32'hDEADBEEF}) begin
      bad = bad + 1; $display("FAIL zw_latch: got %h %b %h, need 004 1 deadbeef", paddr, pwrite, pwdata);
    end
    tick();
    total = total + 1;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      bad = bad + 1; $display("FAIL zw_access: psel/pen/rsp got %b, need 110", {psel, penable, rsp_valid});
    end
    tick();
    total = total + 2;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'd0}) begin
      bad = bad + 1; $display("FAIL zw_rsp: got %b %b %h, need 1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    if ({psel, penable, cmd_ready, paddr} !== {3'b001, 10'h004}) begin
      bad = bad + 1; $display("FAIL zw_idle_after: got %b %h, need 001 004", {psel, penable, cmd_ready}, paddr);
    end
    tick();
    total = total + 1;
    if (rsp_valid !== 1'b0) begin
      bad = bad + 1; $display("FAIL zw_rsp_pulse: got %b, need 0", rsp_valid);
    end
  endtask

  task automatic test_wait_read();
    pready = 1'b0; prdata = 32'hAAAA5555;
    cmd_addr = 10'h3FC; cmd_write = 1'b0; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total = total + 1;
      if ({psel, penable, pwrite, paddr, rsp_valid} !== {3'b110, 10'h3FC, 1'b0}) begin
        bad = bad + 1; $display("FAIL wr_wait%0d: got %b %h %b, need 110 3fc 0", i, {psel, penable, pwrite}, paddr, rsp_valid);
      end
      tick();
    end
    pready = 1'b1; prdata = 32'h12345678;
    tick();
    pready = 1'b0; prdata = 32'hFFFFFFFF;
    total = total + 2;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      bad = bad + 1; $display("FAIL wr_rsp: got %b %b %h, need 1 0 12345678", rsp_valid, rsp_err, rsp_rdata);
    end
    if ({psel, penable} !== 2'b00) begin
      bad = bad + 1; $display("FAIL wr_release: got %b, need 00", {psel, penable});
    end
    tick();
    total = total + 1;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h12345678}) begin
      bad = bad + 1; $display("FAIL wr_hold: got %b %h, need 0 12345678", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  a [4];
    logic        w [4];
    logic [31:0] d [4];
    logic [31:0] e [4];
    int n = 0, rn = 0, cyc = 0, last = 0;
    logic acc, prev_psel;
    a = '{10'h010, 10'h020, 10'h030, 10'h040};
    w = '{1'b1, 1'b0, 1'b1, 1'b0};
    d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    e = '{32'h0, 32'h0BADF00D, 32'h0, 32'h0BADF00D};
    prdata = 32'h0BADF00D; pready = 1'b1;
    cmd_addr = a[0]; cmd_write = w[0]; cmd_wdata = d[0]; cmd_valid = 1'b1;
    prev_psel = psel;
    while (rn < 4 && cyc < 40) begin
      acc = cmd_ready && cmd_valid;
      if (acc) begin
        if (n > 0) begin
          total = total + 1;
          if ({cyc - last, psel, prev_psel} !== {32'd3, 1'b0, 1'b1}) begin
            bad = bad + 1; $display("FAIL b2b_spacing%0d: gap=%0d psel=%b prev=%b, need 3 0 1", n, cyc - last, psel, prev_psel);
          end
        end
        last = cyc;
        n = n + 1;
      end
      prev_psel = psel;
      tick();
      cyc = cyc + 1;
      if (acc) begin
        total = total + 1;
        if ({paddr, pwrite, pwdata} !== {a[n-1], w[n-1], d[n-1]}) begin
          bad = bad + 1; $display("FAIL b2b_latch%0d: got %h %b %h, need %h %b %h", n - 1, paddr, pwrite, pwdata, a[n-1], w[n-1], d[n-1]);
        end
        if (n < 4) begin
          cmd_addr = a[n]; cmd_write = w[n]; cmd_wdata = d[n];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        total = total + 1;
        if (rsp_rdata !== e[rn]) begin
          bad = bad + 1; $display("FAIL b2b_rdata%0d: got %h, need %h", rn, rsp_rdata, e[rn]);
        end
        rn = rn + 1;
      end
    end
    cmd_valid = 1'b0;
    total = total + 1;
    if ({n, rn} !== {32'd4, 32'd4}) begin
      bad = bad + 1; $display("FAIL b2b_counts: accepts=%0d rsps=%0d, need 4 4", n, rn);
    end
    tick();
  endtask

  task automatic test_reset_access();
    int rsp_seen = 0;
    pready = 1'b0;
    cmd_addr = 10'h0C8; cmd_write = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    #2;
    PRESETn = 1'b0;
    #1;
    total = total + 1;
    if ({psel, penable, cmd_ready} !== 3'b000) begin
      bad = bad + 1; $display("FAIL rst_async: psel/pen/ready got %b, need 000", {psel, penable, cmd_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid) rsp_seen = rsp_seen + 1;
    end
    PRESETn = 1'b1;
    tick();
    if (rsp_valid) rsp_seen = rsp_seen + 1;
    total = total + 1;
    if (rsp_seen !== 0) begin
      bad = bad + 1; $display("FAIL rst_no_rsp: got %0d responses, need 0", rsp_seen);
    end
    pready = 1'b1; prdata = 32'h5A5A5A5A;
    cmd_addr = 10'h100; cmd_write = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    total = total + 1;
    if ({rsp_valid, rsp_err, rsp_rdata, paddr} !== {1'b1, 1'b0, 32'h5A5A5A5A, 10'h100}) begin
      bad = bad + 1; $display("FAIL rst_fresh_read: got %b %b %h %h, need 1 0 5a5a5a5a 100", rsp_valid, rsp_err, rsp_rdata, paddr);
    end
    tick();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    pready = 1'b0; prdata = 32'h77777777;
    cmd_addr = 10'h2A0; cmd_write = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total = total + 1;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
        bad = bad + 1; $display("FAIL to_wait%0d: got %b, need 110", i, {psel, penable, rsp_valid});
      end
      tick();
    end
    tick();
    total = total + 1;
    if ({rsp_valid, rsp_err, rsp_rdata, psel, penable} !== {2'b11, 32'd0, 2'b00}) begin
      bad = bad + 1; $display("FAIL to_expire: got %b %b %h %b, need 1 1 00000000 00", rsp_valid, rsp_err, rsp_rdata, {psel, penable});
    end
    cmd_addr = 10'h2A4; cmd_write = 1'b1; cmd_wdata = 32'h01020304; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) tick();
    pready = 1'b1;
    tick();
    pready = 1'b0;
    total = total + 1;
    if ({rsp_valid, rsp_err, psel} !== 3'b100) begin
      bad = bad + 1; $display("FAIL to_late_ready: got %b, need 100", {rsp_valid, rsp_err, psel});
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    pready = 1'b0;
    cmd_addr = 10'h155; cmd_write = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      total = total + 1;
      if ({psel, penable, rsp_valid, rsp_err} !== 4'b1100) begin
        bad = bad + 1; $display("FAIL nto_wait%0d: got %b, need 1100", i, {psel, penable, rsp_valid, rsp_err});
      end
      tick();
    end
    pready = 1'b1; prdata = 32'h600DCAFE;
    tick();
    pready = 1'b0;
    total = total + 1;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h600DCAFE}) begin
      bad = bad + 1; $display("FAIL nto_rsp: got %b %b %h, need 1 0 600dcafe", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within 200000 time units");
    $fatal(1, "bench timeout");
  end

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; prdata = '0; pready = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_back_to_back();
    test_reset_access();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
